// File: rtl/pcie_link_supervisor.sv
// pcie_link_supervisor: PERST# qualification, PCIe core reset sequencing, link supervision and status LEDs
`timescale 1ns/1ps
module pcie_link_supervisor #(
    parameter int HOLD_CYC    = 25000000,
    parameter int STABLE_CYC  = 250000,
    parameter int TIMEOUT_CYC = 250000000,
    parameter int MAX_RETRY   = 3,
    parameter int BLINK_CYC   = 125000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcie_perst_n,
    input  logic        pcie_link_up,
    input  logic        clr_cnt,
    output logic        core_rst_n,
    output logic        link_good,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] drop_cnt,
    output logic [7:0]  LED
);
    localparam logic [2:0] IDLE = 3'd0, HOLD = 3'd1, TRAIN = 3'd2, UP = 3'd3, LOST = 3'd4, FAIL = 3'd5;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);

    logic [1:0]    perst_sync_q, link_sync_q;
    logic          perst_s, link_s;
    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    retry_q, retry_d;
    logic [15:0]   drop_q, drop_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          core_rst_n_q, core_rst_n_d, link_good_q, link_good_d;
    logic [7:0]    led_q, led_d;

    assign perst_s = perst_sync_q[1];
    assign link_s  = link_sync_q[1];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: if (perst_s) begin
                state_d = HOLD;
                hold_d  = '0;
            end
            HOLD: if (hold_q == HW'(HOLD_CYC - 1)) begin
                state_d = TRAIN;
                tmo_d   = '0;
                stab_d  = '0;
            end else begin
                hold_d = hold_q + HW'(1);
            end
            TRAIN: begin
                tmo_d  = tmo_q + TW'(1);
                stab_d = link_s ? stab_q + SW'(1) : '0;
                // a link that qualifies on the timeout cycle still counts as up
                if (stab_q == SW'(STABLE_CYC)) begin
                    state_d = UP;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == 4'(MAX_RETRY)) ? FAIL : HOLD;
                    hold_d  = '0;
                end
            end
            UP:      state_d = link_s ? UP : LOST;
            LOST: begin
                state_d = HOLD;
                hold_d  = '0;
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
        if (!perst_s) state_d = IDLE;
        if (state_d == IDLE || state_d == UP) retry_d = '0;
        drop_d = clr_cnt ? '0 : (state_q == LOST && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        blink_cnt_d = (blink_cnt_q == BW'(BLINK_CYC - 1)) ? '0 : blink_cnt_q + BW'(1);
        blink_d = blink_q ^ (blink_cnt_q == BW'(BLINK_CYC - 1));
        core_rst_n_d = state_d == TRAIN || state_d == UP || state_d == LOST;
        link_good_d = state_d == UP;
        led_d = {drop_d[3:0], state_d == FAIL, state_d == TRAIN && blink_d, link_good_d, blink_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perst_sync_q <= '0;
            link_sync_q  <= '0;
            state_q      <= IDLE;
            hold_q       <= '0;
            stab_q       <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            drop_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            link_good_q  <= 1'b0;
            led_q        <= '0;
        end else begin
            perst_sync_q <= {perst_sync_q[0], pcie_perst_n};
            link_sync_q  <= {link_sync_q[0], pcie_link_up};
            state_q      <= state_d;
            hold_q       <= hold_d;
            stab_q       <= stab_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            drop_q       <= drop_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            core_rst_n_q <= core_rst_n_d;
            link_good_q  <= link_good_d;
            led_q        <= led_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign link_good  = link_good_q;
    assign state      = state_q;
    assign retry_cnt  = retry_q;
    assign drop_cnt   = drop_q;
    assign LED        = led_q;
endmodule

// File: tb/tb_pcie_link_supervisor.sv
// tb_pcie_link_supervisor: scenario tasks checked every cycle against a behavioural model
`timescale 1ns/1ps
module tb_pcie_link_supervisor;
    localparam int HOLD = 8, STABLE = 4, TMO = 32, RETRY = 3, BLINK = 16;

    logic        clk = 1'b0, rst_n = 1'b0, perst_n = 1'b0, link_up = 1'b0, clr_cnt = 1'b0;
    logic        core_rst_n, link_good;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] drop_cnt;
    logic [7:0]  led;
    logic [32:0] obs;
    int          total = 0, bad = 0;

    logic        m_ps1, m_ps, m_ls1, m_ls;
    logic [2:0]  m_st, m_ns;
    logic [3:0]  m_retry;
    logic [15:0] m_drop;
    int          m_tis, m_run, m_n;

    pcie_link_supervisor #(.HOLD_CYC(HOLD), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO),
                           .MAX_RETRY(RETRY), .BLINK_CYC(BLINK)) dut (
        .clk(clk), .rst_n(rst_n), .pcie_perst_n(perst_n), .pcie_link_up(link_up),
        .clr_cnt(clr_cnt), .core_rst_n(core_rst_n), .link_good(link_good), .state(state),
        .retry_cnt(retry_cnt), .drop_cnt(drop_cnt), .LED(led)
    );

    assign obs = {core_rst_n, link_good, state, retry_cnt, drop_cnt, led};
    always #5 clk = ~clk;

    task automatic model_zero();
        {m_ps1, m_ps, m_ls1, m_ls} = '0;
        m_st = 3'd0; m_ns = 3'd0; m_retry = '0; m_drop = '0;
        m_tis = 0; m_run = 0; m_n = 0;
    endtask

    // one clock of behaviour: time-in-state and consecutive-link-high run lengths drive the decisions
    task automatic model_step();
        if (!rst_n) begin
            model_zero();
            return;
        end
        m_ns = m_st;
        case (m_st)
            3'd0: if (m_ps) m_ns = 3'd1;
            3'd1: if (m_tis == HOLD - 1) m_ns = 3'd2;
            3'd2: if (m_run >= STABLE) m_ns = 3'd3;
                  else if (m_tis == TMO - 1) begin
                      m_retry = m_retry + 4'd1;
                      m_ns = (m_retry == RETRY) ? 3'd5 : 3'd1;
                  end
            3'd3: if (!m_ls) m_ns = 3'd4;
            3'd4: m_ns = 3'd1;
            default: ;
        endcase
        if (!m_ps) m_ns = 3'd0;
        if (m_ns == 3'd0 || m_ns == 3'd3) m_retry = '0;
        m_drop = clr_cnt ? 16'h0 : (m_st == 3'd4 && m_drop != 16'hFFFF) ? m_drop + 16'd1 : m_drop;
        m_run = (m_st == 3'd2 && m_ns == 3'd2 && m_ls) ? m_run + 1 : 0;
        m_tis = (m_ns == m_st) ? m_tis + 1 : 0;
        m_st = m_ns;
        m_n++;
        m_ps = m_ps1; m_ps1 = perst_n;
        m_ls = m_ls1; m_ls1 = link_up;
    endtask

    function automatic logic [32:0] exp_vec();
        logic b;
        b = ((m_n / BLINK) % 2) == 1;
        return {m_st inside {3'd2, 3'd3, 3'd4}, m_st == 3'd3, m_st, m_retry, m_drop,
                m_drop[3:0], m_st == 3'd5, m_st == 3'd2 && b, m_st == 3'd3, b};
    endfunction

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; perst_n = 1'b0; link_up = 1'b0; clr_cnt = 1'b0;
        model_zero();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 33'h0) begin bad++; $display("FAIL reset_vals: got %h want %h", obs, 33'h0); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_bringup();
        int t_core = -1, t_up = -1;
        do_reset();
        perst_n = 1'b1; link_up = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL bringup c%0d: got %h want %h", i, obs, exp_vec()); end
            if (i == 3) begin
                total++;
                if (state !== 3'd1) begin bad++; $display("FAIL hold_at_3: got %0d want 1", state); end
            end
            if (core_rst_n === 1'b1 && t_core < 0) t_core = i;
            if (state === 3'd3 && t_up < 0) t_up = i;
        end
        total++;
        if (t_core != 11) begin bad++; $display("FAIL core_release_cycle: got %0d want 11", t_core); end
        total++;
        if (t_up != 16) begin bad++; $display("FAIL up_cycle: got %0d want 16", t_up); end
        total++;
        if (led[1] !== 1'b1) begin bad++; $display("FAIL led1_up: got %b want 1", led[1]); end
    endtask

    task automatic test_link_drop();
        int lost = 0, low = 0;
        link_up = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) link_up = 1'b1;
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL link_drop c%0d: got %h want %h", i, obs, exp_vec()); end
            if (state === 3'd4) lost++;
            if (core_rst_n === 1'b0) low++;
        end
        total++;
        if (lost != 1) begin bad++; $display("FAIL lost_cycles: got %0d want 1", lost); end
        total++;
        if (low != 8) begin bad++; $display("FAIL core_low_cycles: got %0d want 8", low); end
        total++;
        if ({state, drop_cnt, led[7:4]} !== {3'd3, 16'd1, 4'h1}) begin
            bad++; $display("FAIL retrain_state_drop: got %h want %h", {state, drop_cnt, led[7:4]}, {3'd3, 16'd1, 4'h1});
        end
    endtask

    task automatic test_fail();
        int steps[$];
        int code;
        logic [3:0] last = '0;
        logic seen_idle = 1'b0;
        do_reset();
        perst_n = 1'b1; link_up = 1'b0;
        for (int i = 0; i < 200 && state !== 3'd5; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL fail_path c%0d: got %h want %h", i, obs, exp_vec()); end
            if (retry_cnt !== last) begin steps.push_back(int'(retry_cnt)); last = retry_cnt; end
        end
        code = (steps.size() == 3) ? steps[0] * 100 + steps[1] * 10 + steps[2] : -1;
        total++;
        if (code != 123) begin bad++; $display("FAIL retry_steps: got %0d want 123", code); end
        total++;
        if ({state, core_rst_n, led[3]} !== {3'd5, 1'b0, 1'b1}) begin
            bad++; $display("FAIL fail_state: got %h want %h", {state, core_rst_n, led[3]}, {3'd5, 1'b0, 1'b1});
        end
        repeat (3) tick();
        perst_n = 1'b0;
        tick();
        perst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL fail_exit c%0d: got %h want %h", i, obs, exp_vec()); end
            if (state === 3'd0) begin
                seen_idle = 1'b1;
                total++;
                if (retry_cnt !== 4'd0) begin bad++; $display("FAIL idle_retry: got %0d want 0", retry_cnt); end
            end
        end
        total++;
        if (!seen_idle) begin bad++; $display("FAIL perst_pulse_idle: got 0 want 1"); end
    endtask

    task automatic test_toggle();
        int ph, train = 0;
        logic done = 1'b0;
        do_reset();
        perst_n = 1'b1;
        ph = int'($urandom_range(0, 2));
        for (int i = 0; i < 120 && !done; i++) begin
            link_up = ((i + ph) % 3) != 2;
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL toggle c%0d: got %h want %h", i, obs, exp_vec()); end
            if (state === 3'd2) train++;
            else if (train > 0) done = 1'b1;
        end
        total++;
        if ({done, state, retry_cnt} !== {1'b1, 3'd1, 4'd1}) begin
            bad++; $display("FAIL toggle_timeout: got %h want %h", {done, state, retry_cnt}, {1'b1, 3'd1, 4'd1});
        end
        total++;
        if (train != TMO) begin bad++; $display("FAIL train_window: got %0d want %0d", train, TMO); end
    endtask

    task automatic test_saturate();
        do_reset();
        perst_n = 1'b1; link_up = 1'b1;
        repeat (20) tick();
        force dut.drop_q = 16'hFFFE;
        tick();
        release dut.drop_q;
        m_drop = 16'hFFFE;
        for (int d = 0; d < 2; d++) begin
            link_up = 1'b0;
            for (int i = 0; i < 24; i++) begin
                if (i == 3) link_up = 1'b1;
                tick();
                total++;
                if (obs !== exp_vec()) begin bad++; $display("FAIL saturate d%0d c%0d: got %h want %h", d, i, obs, exp_vec()); end
            end
        end
        total++;
        if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL drop_sat: got %h want ffff", drop_cnt); end
        link_up = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 3) link_up = 1'b1;
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL clr_in_lost c%0d: got %h want %h", i, obs, exp_vec()); end
            clr_cnt = state === 3'd4;
        end
        clr_cnt = 1'b0;
        total++;
        if (drop_cnt !== 16'h0) begin bad++; $display("FAIL drop_clr: got %h want 0", drop_cnt); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        perst_n = 1'b1; link_up = 1'b1;
        repeat (20) tick();
        total++;
        if (state !== 3'd3) begin bad++; $display("FAIL pre_reset_up: got %0d want 3", state); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 33'h0) begin bad++; $display("FAIL async_reset: got %h want %h", obs, 33'h0); end
        model_zero();
        tick();
        rst_n = 1'b1;
        link_up = 1'b0;
        for (int i = 0; i < 30 && state !== 3'd2; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL rebring c%0d: got %h want %h", i, obs, exp_vec()); end
        end
        perst_n = 1'b0;
        for (int i = 0; i < 10 && state !== 3'd0; i++) begin
            tick();
            n++;
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL perst_drop c%0d: got %h want %h", i, obs, exp_vec()); end
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL perst_idle_latency: got %0d want 3", n); end
    endtask

    task automatic test_random();
        do_reset();
        perst_n = 1'b1; link_up = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) perst_n = 1'b0;
            else if (!perst_n && $urandom_range(0, 2) == 0) perst_n = 1'b1;
            if ($urandom_range(0, 11) == 0) link_up = ~link_up;
            clr_cnt = $urandom_range(0, 49) == 0;
            tick();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random c%0d: got %h want %h", i, obs, exp_vec()); end
        end
        clr_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_link_drop();
        test_fail();
        test_toggle();
        test_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
